dbus_ram_responder: RTL and testbench
=====================================

# dbus_ram_responder

Responder end of the pipeline's data-bus protocol. It accepts `dbus_req_t` requests from the memory stage, models a fixed-latency byte-strobed data RAM, and returns `dbus_resp_t` responses. The memory stage consumes these responses. The block is the simulation and FPGA data-memory target behind the core's data port, and it replaces any zero-latency behavioural memory.

## Interface
- `DEPTH_WORDS`, default 4096: number of 64-bit words. Must be a power of two.
- `LATENCY`, default 2: wait cycles between request acceptance and response. Range 0–15.
- `clk` input, 1: clock, rising edge.
- `reset` input, 1: asynchronous, active-low reset.
- `dreq` input, `dbus_req_t`: fields `valid`, `addr` (u64), `size` (msize_t), `strobe` (u8), `data` (u64).
- `dresp` output, `dbus_resp_t`: fields `addr_ok`, `data_ok`, `data` (u64).
- `misalign` output, 1: the current response is for an address not aligned to `size`. Valid only while `data_ok` is high.
- `busy` output, 1: a request is in flight, so the FSM is not IDLE.

## Operation
- FSM states:
  - IDLE → WAIT when `dreq.valid` is sampled and `LATENCY`>0.
  - IDLE → RESP when `dreq.valid` is sampled and `LATENCY`==0.
  - WAIT → RESP when the counter reaches 1.
  - RESP → IDLE unconditionally.
- Acceptance:
  - In IDLE with `dreq.valid`=1, the block latches `addr`, `size`, `strobe` and `data`.
  - It loads a 4-bit counter with `LATENCY`.
  - Inputs are ignored outside IDLE.
- Word index is `addr[3 +: log2(DEPTH_WORDS)]`. Upper address bits are discarded, so accesses wrap modulo the RAM size.
- Read data:
  - The full 64-bit word at the latched index, registered on entry to RESP.
  - No byte lane shifting; the memory stage extracts by `size` and `addr[2:0]`.
  - Every access returns read data, including writes. On a write, `dresp.data` is the pre-write word.
- Write:
  - Any nonzero `strobe` is a write.
  - Byte lane i is updated with `data[8i+7:8i]` when `strobe[i]`=1.
  - The update commits at the clock edge that ends RESP.
  - `strobe`=0 is a pure read.
- Misalignment:
  - Defined as `addr[2:0]` not a multiple of the access width (1, 2, 4 or 8 bytes).
  - The access is still performed as given. Only `misalign` is raised alongside `data_ok`.
  - Exception generation belongs to the memory stage.
- `addr_ok` and `data_ok` are both driven high only in RESP. Elsewhere both are 0, and `dresp.data` holds its last value.
- Protocol: the requester holds `dreq` stable until it sees `data_ok`. If `valid` drops mid-flight, the latched request still completes: the write is committed and `data_ok` still pulses.

## Timing
- Edge E0 samples `valid` in IDLE. `data_ok` is high for exactly one cycle, beginning LATENCY+1 edges after E0.
- Back-to-back behaviour:
  - The FSM is back in IDLE the cycle after RESP.
  - A still-asserted `valid` is sampled at that edge.
  - Throughput is one request per LATENCY+2 cycles.
  - Because the requester holds `valid` until `data_ok`, the same request is not re-accepted. The requester updates `dreq` in the cycle after `data_ok`.
- Read-after-write: a request accepted right after a write's RESP observes the written bytes.
- Reset (`reset`=0):
  - Takes effect immediately, regardless of clock.
  - FSM goes to IDLE, counter to 0.
  - `dresp.addr_ok`, `dresp.data_ok`, `dresp.data`, `misalign` and `busy` all go to 0.
  - An in-flight write is dropped and its `data_ok` is never produced.
- The RAM array is never reset; its contents survive reset.

## Structure
- Package `common` (existing) supplies `dbus_req_t`, `dbus_resp_t`, `msize_t`, `u64`, `u8` and `word_t`.
- Add to `common`:
  - an FSM enum `dram_state_t` {IDLE, WAIT, RESP};
  - a function `msize_bytes(msize_t)` returning the access width.
- One sub-module, `byte_we_ram`: single-port, `DEPTH_WORDS`×64, synchronous read, per-byte write enable, no reset. The responder instantiates it and owns only the FSM, the latches and the misalign logic.

## Test plan
- Basic read/write:
  - Stimulus: LATENCY=2. Write `addr`=0x80000010, MSIZE8, `strobe`=0xFF, `data`=0x1122334455667788, then read the same address.
  - Required: `data_ok` 3 cycles after each accept, and the read returns 0x1122334455667788.
- Byte strobe:
  - Stimulus: write `strobe`=0x0F with `data`=0xAAAAAAAA_BBBBBBBB over the word above, then read it back.
  - Required: read returns 0x11223344_BBBBBBBB.
- Zero latency and wrap:
  - Stimulus: LATENCY=0, DEPTH_WORDS=16. Write 0x5 to word address 0x80, then read address 0x00.
  - Required: `data_ok` one cycle after each accept, and the read returns 0x5.
- Misalign:
  - Stimulus: read `addr`=0x...6, MSIZE4.
  - Required: `misalign`=1 with `data_ok`, and `data` is the containing word.
  - Stimulus: `addr`=0x...4, MSIZE4. Required: `misalign`=0.
- Reset mid-flight:
  - Stimulus: deassert `reset` one cycle after a write is accepted, then release and read the address.
  - Required: all outputs go to 0 immediately, no `data_ok` is produced, and the read returns the old value.
- Held valid:
  - Stimulus: hold `valid`=1 with an unchanged request across three responses, changing the address after each `data_ok`.
  - Required: exactly one `data_ok` per request, spaced LATENCY+2 cycles apart.

Source files
------------

// File: rtl/dbus_ram_responder_pkg.sv
// Shared data-bus types for the core's data port, plus the responder FSM
// encoding and the access-width helper used by misalignment detection.
package common;

    typedef logic [63:0] u64;
    typedef logic [7:0]  u8;
    typedef u64          word_t;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic   valid;
        u64     addr;
        msize_t size;
        u8      strobe;
        u64     data;
    } dbus_req_t;

    typedef struct packed {
        logic addr_ok;
        logic data_ok;
        u64   data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dram_state_t;

    function automatic logic [3:0] msize_bytes(input msize_t size);
        logic [3:0] bytes;
        case (size)
            MSIZE1:  bytes = 4'd1;
            MSIZE2:  bytes = 4'd2;
            MSIZE4:  bytes = 4'd4;
            MSIZE8:  bytes = 4'd8;
            default: bytes = 4'd8;
        endcase
        return bytes;
    endfunction

endpackage

// File: rtl/dbus_ram_responder_ram.sv
// Single-port 64-bit data RAM: synchronous read, per-byte write enable, no reset.
module byte_we_ram
    import common::*;
#(
    parameter int DEPTH_WORDS = 4096,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_re,
    input  u8             i_we,
    input  logic [AW-1:0] i_addr,
    input  word_t         i_wdata,
    output word_t         o_rdata
);

    word_t r_mem [DEPTH_WORDS];
    word_t r_rdata;

    // Byte-lane writes and registered read; the read register holds between reads.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dbus_ram_responder.sv
// Fixed-latency data-bus responder in front of a byte-strobed RAM.
// Reads on entry to RESP, commits writes at the edge leaving RESP.
module dbus_ram_responder
    import common::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       misalign,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dram_state_t   r_state;
    dram_state_t   w_next;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_idx;
    logic [2:0]    r_off;
    msize_t        r_size;
    u8             r_strobe;
    word_t         r_wdata;
    logic          r_ok;
    logic          r_mis;
    logic          r_busy;
    logic          r_rvld;

    logic          w_accept;
    logic          w_enter_resp;
    logic [AW-1:0] w_cur_idx;
    logic [2:0]    w_cur_off;
    msize_t        w_cur_size;
    logic [3:0]    w_bytes;
    logic [2:0]    w_mask;
    logic          w_mis;
    u8             w_we;
    word_t         w_rdata;
    logic          w_unused_addr;

    assign w_accept     = (r_state == IDLE) && dreq.valid;
    assign w_enter_resp = (w_next == RESP);

    // With zero latency the RAM read happens on the accepting edge, so the
    // address and size come straight from the request while in IDLE.
    assign w_cur_idx  = (r_state == IDLE) ? dreq.addr[3 +: AW] : r_idx;
    assign w_cur_off  = (r_state == IDLE) ? dreq.addr[2:0]     : r_off;
    assign w_cur_size = (r_state == IDLE) ? dreq.size          : r_size;

    assign w_bytes = msize_bytes(w_cur_size);
    assign w_mask  = 3'(w_bytes - 4'd1);
    assign w_mis   = |(w_cur_off & w_mask);
    assign w_we    = (r_state == RESP) ? r_strobe : 8'h00;

    assign w_unused_addr = ^dreq.addr[63:AW+3];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (dreq.valid) begin
                    w_next = (LATENCY == 0) ? RESP : WAIT;
                end else begin
                    w_next = IDLE;
                end
            end
            WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next = RESP;
                end else begin
                    w_next = WAIT;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request latches, latency counter and registered response flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= 4'd0;
            r_idx    <= '0;
            r_off    <= 3'd0;
            r_size   <= MSIZE1;
            r_strobe <= 8'h00;
            r_wdata  <= 64'd0;
            r_ok     <= 1'b0;
            r_mis    <= 1'b0;
            r_busy   <= 1'b0;
            r_rvld   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idx    <= dreq.addr[3 +: AW];
                r_off    <= dreq.addr[2:0];
                r_size   <= dreq.size;
                r_strobe <= dreq.strobe;
                r_wdata  <= dreq.data;
                r_cnt    <= 4'(LATENCY);
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            r_ok   <= w_enter_resp;
            r_mis  <= w_enter_resp & w_mis;
            r_busy <= (w_next != IDLE);
            if (w_enter_resp) begin
                r_rvld <= 1'b1;
            end
        end
    end

    byte_we_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .i_re    (w_enter_resp),
        .i_we    (w_we),
        .i_addr  (w_cur_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    // Response drive; data reads as zero until the first read after reset.
    always_comb begin
        dresp.addr_ok = r_ok;
        dresp.data_ok = r_ok;
        dresp.data    = r_rvld ? w_rdata : 64'd0;
    end

    assign misalign = r_mis;
    assign busy     = r_busy;

endmodule

// File: tb/tb_dbus_ram_responder.sv
// Directed bench for dbus_ram_responder: one instance at LATENCY=2/4096 words,
// one at LATENCY=0/16 words, sharing clock and reset.
module tb_dbus_ram_responder;
    import common::*;

    logic       clk;
    logic       reset;
    dbus_req_t  req_a, req_b;
    dbus_resp_t resp_a, resp_b;
    logic       mis_a, mis_b, busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    dbus_ram_responder #(.DEPTH_WORDS(4096), .LATENCY(2)) u_dut_a (
        .clk(clk), .reset(reset), .dreq(req_a), .dresp(resp_a),
        .misalign(mis_a), .busy(busy_a)
    );

    dbus_ram_responder #(.DEPTH_WORDS(16), .LATENCY(0)) u_dut_b (
        .clk(clk), .reset(reset), .dreq(req_b), .dresp(resp_b),
        .misalign(mis_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, hold it until data_ok, then drop valid.
    // lat counts negedges after the accepting edge (1 = first cycle after accept).
    task automatic do_txn(input bit sel, input logic [63:0] addr, input msize_t size,
                          input logic [7:0] strb, input logic [63:0] wdata,
                          output logic [63:0] rdata, output logic mis, output int lat);
        dbus_req_t r;
        r = '{valid: 1'b1, addr: addr, size: size, strobe: strb, data: wdata};
        lat = -1;
        rdata = 64'd0;
        mis = 1'b0;
        @(negedge clk);
        if (sel) req_b = r; else req_a = r;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if ((sel ? resp_b.data_ok : resp_a.data_ok) === 1'b1) begin
                rdata = sel ? resp_b.data : resp_a.data;
                mis   = sel ? mis_b : mis_a;
                lat   = n;
                break;
            end
        end
        if (sel) req_b.valid = 1'b0; else req_a.valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++;
        if ({resp_a.addr_ok, resp_a.data_ok, mis_a, busy_a} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags_a: got %b want 0000", {resp_a.addr_ok, resp_a.data_ok, mis_a, busy_a});
        end
        checks++;
        if (resp_a.data !== 64'd0 || resp_b.data !== 64'd0) begin
            errors++; $display("FAIL reset_data: got %h/%h want 0", resp_a.data, resp_b.data);
        end
        checks++;
        if ({resp_b.addr_ok, resp_b.data_ok, mis_b, busy_b} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags_b: got %b want 0000", {resp_b.addr_ok, resp_b.data_ok, mis_b, busy_b});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [63:0] d; logic m; int l;
        do_txn(1'b0, 64'h8000_0010, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, d, m, l);
        checks++;
        if (l !== 3) begin errors++; $display("FAIL basic_wr_lat: got %0d want 3", l); end
        do_txn(1'b0, 64'h8000_0010, MSIZE8, 8'h00, 64'd0, d, m, l);
        checks++;
        if (l !== 3) begin errors++; $display("FAIL basic_rd_lat: got %0d want 3", l); end
        checks++;
        if (d !== 64'h1122_3344_5566_7788) begin
            errors++; $display("FAIL basic_rd_data: got %h want 1122334455667788", d);
        end
        checks++;
        if (m !== 1'b0) begin errors++; $display("FAIL basic_mis: got %b want 0", m); end
    endtask

    task automatic test_strobe();
        logic [63:0] d; logic m; int l;
        do_txn(1'b0, 64'h8000_0010, MSIZE4, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, d, m, l);
        checks++;
        if (d !== 64'h1122_3344_5566_7788) begin
            errors++; $display("FAIL strobe_prewrite: got %h want 1122334455667788", d);
        end
        do_txn(1'b0, 64'h8000_0010, MSIZE8, 8'h00, 64'd0, d, m, l);
        checks++;
        if (d !== 64'h1122_3344_BBBB_BBBB) begin
            errors++; $display("FAIL strobe_rd: got %h want 11223344bbbbbbbb", d);
        end
    endtask

    task automatic test_zero_wrap();
        logic [63:0] d; logic m; int l;
        do_txn(1'b1, 64'h0000_0080, MSIZE8, 8'hFF, 64'h5, d, m, l);
        checks++;
        if (l !== 1) begin errors++; $display("FAIL zl_wr_lat: got %0d want 1", l); end
        do_txn(1'b1, 64'h0000_0000, MSIZE8, 8'h00, 64'd0, d, m, l);
        checks++;
        if (l !== 1) begin errors++; $display("FAIL zl_rd_lat: got %0d want 1", l); end
        checks++;
        if (d !== 64'h5) begin errors++; $display("FAIL zl_wrap_data: got %h want 5", d); end
    endtask

    task automatic test_misalign();
        logic [63:0] d; logic m; int l;
        do_txn(1'b0, 64'h8000_0016, MSIZE4, 8'h00, 64'd0, d, m, l);
        checks++;
        if (m !== 1'b1) begin errors++; $display("FAIL mis_w4_off6: got %b want 1", m); end
        checks++;
        if (d !== 64'h1122_3344_BBBB_BBBB) begin
            errors++; $display("FAIL mis_word: got %h want 11223344bbbbbbbb", d);
        end
        do_txn(1'b0, 64'h8000_0014, MSIZE4, 8'h00, 64'd0, d, m, l);
        checks++;
        if (m !== 1'b0) begin errors++; $display("FAIL mis_w4_off4: got %b want 0", m); end
        do_txn(1'b0, 64'h8000_0014, MSIZE8, 8'h00, 64'd0, d, m, l);
        checks++;
        if (m !== 1'b1) begin errors++; $display("FAIL mis_w8_off4: got %b want 1", m); end
        do_txn(1'b0, 64'h8000_0017, MSIZE1, 8'h00, 64'd0, d, m, l);
        checks++;
        if (m !== 1'b0) begin errors++; $display("FAIL mis_w1_off7: got %b want 0", m); end
        do_txn(1'b1, 64'h0000_0003, MSIZE2, 8'h00, 64'd0, d, m, l);
        checks++;
        if (m !== 1'b1) begin errors++; $display("FAIL mis_zl_w2_off3: got %b want 1", m); end
    endtask

    task automatic test_reset_midflight();
        logic [63:0] d; logic m; int l;
        bit seen_ok;
        @(negedge clk);
        req_a = '{valid: 1'b1, addr: 64'h8000_0010, size: MSIZE8, strobe: 8'hFF,
                  data: 64'hDEAD_BEEF_CAFE_F00D};
        @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL midflight_busy: got %b want 1", busy_a); end
        reset = 1'b0;
        #1;
        checks++;
        if ({resp_a.addr_ok, resp_a.data_ok, mis_a, busy_a} !== 4'b0000 || resp_a.data !== 64'd0) begin
            errors++; $display("FAIL midflight_async_clear: got %b/%h want 0000/0",
                               {resp_a.addr_ok, resp_a.data_ok, mis_a, busy_a}, resp_a.data);
        end
        seen_ok = 1'b0;
        repeat (2) @(negedge clk);
        req_a.valid = 1'b0;
        reset = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (resp_a.data_ok !== 1'b0) seen_ok = 1'b1;
        end
        checks++;
        if (seen_ok) begin errors++; $display("FAIL midflight_no_ok: got data_ok want none"); end
        do_txn(1'b0, 64'h8000_0010, MSIZE8, 8'h00, 64'd0, d, m, l);
        checks++;
        if (d !== 64'h1122_3344_BBBB_BBBB) begin
            errors++; $display("FAIL midflight_dropped: got %h want 11223344bbbbbbbb", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d; logic m; int l;
        logic [63:0] addrs [3];
        logic [63:0] exp_d [3];
        logic [63:0] got [3];
        int pos [3];
        int cnt;
        bit prev;
        addrs[0] = 64'h8000_0010; exp_d[0] = 64'h1122_3344_BBBB_BBBB;
        addrs[1] = 64'h0000_0020; exp_d[1] = 64'h0000_0000_0000_00A1;
        addrs[2] = 64'h0000_0028; exp_d[2] = 64'h0000_0000_0000_00B2;
        do_txn(1'b0, addrs[1], MSIZE8, 8'hFF, exp_d[1], d, m, l);
        do_txn(1'b0, addrs[2], MSIZE8, 8'hFF, exp_d[2], d, m, l);
        cnt = 0; prev = 1'b0;
        for (int i = 0; i < 3; i++) begin pos[i] = -1; got[i] = 64'd0; end
        @(negedge clk);
        req_a = '{valid: 1'b1, addr: addrs[0], size: MSIZE8, strobe: 8'h00, data: 64'd0};
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (prev) begin
                if (cnt < 3) req_a.addr = addrs[cnt];
                else req_a.valid = 1'b0;
            end
            prev = resp_a.data_ok;
            if (resp_a.data_ok === 1'b1) begin
                if (cnt < 3) begin pos[cnt] = n; got[cnt] = resp_a.data; end
                cnt++;
            end
        end
        req_a.valid = 1'b0;
        checks++;
        if (cnt !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", cnt); end
        checks++;
        if (pos[0] !== 3) begin errors++; $display("FAIL b2b_first: got %0d want 3", pos[0]); end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (pos[i] - pos[i-1] !== 4) begin
                errors++; $display("FAIL b2b_spacing%0d: got %0d want 4", i, pos[i] - pos[i-1]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== exp_d[i]) begin
                errors++; $display("FAIL b2b_data%0d: got %h want %h", i, got[i], exp_d[i]);
            end
        end
    endtask

    initial begin
        req_a = '0;
        req_b = '0;
        test_reset();
        test_basic();
        test_strobe();
        test_zero_wrap();
        test_misalign();
        test_reset_midflight();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
